// File: rtl/led_frame_builder.sv
// led_frame_builder: double-buffered frame assembly for the WS2801 driver; LED_FRAME_BRIGHTNESS_EN enables brightness scaling.
module led_frame_builder #(
  parameter int LEDS = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [23:0]          in_rgb,
  input  logic                 in_last,
  input  logic [7:0]           brightness,
  output logic                 frame_err,
  output logic [24*LEDS-1:0]   led_rgb,
  output logic                 start,
  input  logic                 done
);
  localparam int IW = LEDS > 1 ? $clog2(LEDS) : 1;
  typedef enum logic {FILL, PEND} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [24*LEDS-1:0] back;
  logic [23:0] px;
  logic accept, at_end, close;
  assign in_ready = state == FILL;
  assign accept = in_valid && in_ready;
  assign at_end = idx == IW'(LEDS - 1);
  assign close = in_last || at_end;
`ifdef LED_FRAME_BRIGHTNESS_EN
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(c) * (16'(b) + 16'd1);
    return p[15:8];
  endfunction
  assign px = {scale(in_rgb[23:16], brightness), scale(in_rgb[15:8], brightness), scale(in_rgb[7:0], brightness)};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign px = in_rgb;
`endif
  // a commit requires start low and done high, so led_rgb never moves under a loading driver
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      back      <= '0;
      led_rgb   <= '0;
      start     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && in_last && !at_end;
      if (start && !done) start <= 1'b0;
      if (accept) begin
        back[24*(LEDS-1-int'(idx)) +: 24] <= px;
        idx <= close ? idx : IW'(idx + 1'b1);
        if (close) state <= PEND;
      end else if (state == PEND && done && !start) begin
        led_rgb <= back;
        back    <= '0;
        idx     <= '0;
        start   <= 1'b1;
        state   <= FILL;
      end
    end
  end
endmodule

// File: tb/tb_led_frame_builder.sv
// tb_led_frame_builder: directed self-checking bench for led_frame_builder with LEDS=4.
module tb_led_frame_builder;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, done = 1;
  logic in_ready, frame_err, start;
  logic [23:0] in_rgb = 0;
  logic [7:0] brightness = 8'hFF;
  logic [95:0] led_rgb;
  int checks = 0, errors = 0;
  logic [23:0] bexp;
  logic [95:0] f1, f2, f3, f4;

  led_frame_builder #(.LEDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb),
    .in_last(in_last), .brightness(brightness), .frame_err(frame_err), .led_rgb(led_rgb),
    .start(start), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] rgb, input logic last);
    check("send_ready", 96'(in_ready), 96'd1);
    in_valid = 1;
    in_rgb = rgb;
    in_last = last;
    step();
    in_valid = 0;
    in_last = 0;
  endtask

  initial begin
`ifdef LED_FRAME_BRIGHTNESS_EN
    bexp = 24'h7F4001;
`else
    bexp = 24'hFF8002;
`endif
    f1 = 96'h800000_FFFFFF_555555_000001;
    f2 = 96'h112233_445566_000000_000000;
    f3 = 96'h010101_020202_030303_040404;
    f4 = 96'h0A0A0A_0B0B0B_0C0C0C_0D0D0D;
    step(); step();
    rst = 0;
    check("rst_ready", 96'(in_ready), 96'd1);
    check("rst_start", 96'(start), 96'd0);
    check("rst_led", led_rgb, 96'd0);
    check("rst_err", 96'(frame_err), 96'd0);
    // full frame with brightness 255
    send(24'h800000, 0); send(24'hFFFFFF, 0); send(24'h555555, 0); send(24'h000001, 1);
    check("full_pend_ready", 96'(in_ready), 96'd0);
    check("full_pend_led", led_rgb, 96'd0);
    check("full_noerr", 96'(frame_err), 96'd0);
    step();
    check("full_led", led_rgb, f1);
    check("full_start", 96'(start), 96'd1);
    check("full_ready", 96'(in_ready), 96'd1);
    // start held while done stays high
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_start", 96'(start), 96'd1);
    end
    done = 0;
    step();
    check("start_fall", 96'(start), 96'd0);
    // short frame
    send(24'h112233, 0); send(24'h445566, 1);
    check("short_err", 96'(frame_err), 96'd1);
    check("short_ready", 96'(in_ready), 96'd0);
    step();
    check("short_err_clr", 96'(frame_err), 96'd0);
    check("short_hold_led", led_rgb, f1);
    done = 1;
    step();
    check("short_led", led_rgb, f2);
    check("short_start", 96'(start), 96'd1);
    done = 0;
    step();
    check("short_start_fall", 96'(start), 96'd0);
    // brightness
    brightness = 8'h7F;
    send(24'hFF8002, 1);
    check("bri_err", 96'(frame_err), 96'd1);
    done = 1;
    step();
    check("bri_led", led_rgb, {bexp, 72'd0});
    done = 0;
    step();
    brightness = 8'hFF;
    // full frame without in_last under backpressure
    send(24'h010101, 0); send(24'h020202, 0); send(24'h030303, 0); send(24'h040404, 0);
    check("bp_ready", 96'(in_ready), 96'd0);
    check("bp_noerr", 96'(frame_err), 96'd0);
    in_valid = 1;
    in_rgb = 24'hAAAAAA;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_stall_ready", 96'(in_ready), 96'd0);
      check("bp_stable", led_rgb, {bexp, 72'd0});
    end
    in_valid = 0;
    done = 1;
    step();
    check("bp_commit", led_rgb, f3);
    check("bp_start", 96'(start), 96'd1);
    check("bp_refill", 96'(in_ready), 96'd1);
    // back-to-back frame waits for start to clear
    send(24'h0A0A0A, 0); send(24'h0B0B0B, 0); send(24'h0C0C0C, 0); send(24'h0D0D0D, 1);
    step();
    check("b2b_wait_start", led_rgb, f3);
    done = 0;
    step();
    check("b2b_start_fall", 96'(start), 96'd0);
    check("b2b_wait_done", led_rgb, f3);
    done = 1;
    step();
    check("b2b_commit", led_rgb, f4);
    done = 0;
    step();
    // reset mid-frame
    send(24'h111111, 0); send(24'h222222, 0);
    rst = 1;
    step();
    rst = 0;
    check("mrst_start", 96'(start), 96'd0);
    check("mrst_ready", 96'(in_ready), 96'd1);
    check("mrst_led", led_rgb, 96'd0);
    send(24'h333333, 0); send(24'h444444, 1);
    done = 1;
    step();
    check("mrst_idx", led_rgb, 96'h333333_444444_000000_000000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
